packet_arbiter_mux: RTL and testbench
=====================================

PACKET_ARBITER_MUX -- requirements
Module: packet_arbiter_mux

Interface
REQ-001 SHALL have parameter SIZE, default 4, number of input channels (SIZE >= 2, need not be a power of 2).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per beat.
REQ-003 SHALL have port clock, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, SIZE, per-channel beat valid.
REQ-006 SHALL have port in_ready, output, SIZE, per-channel beat accepted.
REQ-007 SHALL have port in_data, input, SIZE*WIDTH, channel i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last, input, SIZE, per-channel last beat of packet.
REQ-009 SHALL have port out_valid, output, 1, registered output beat valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts output beat.
REQ-011 SHALL have port out_data, output, WIDTH, registered beat data.
REQ-012 SHALL have port out_last, output, 1, registered last flag.
REQ-013 SHALL have port out_channel, output, CHANNEL_WIDTH = $clog2(SIZE), source channel index of current output beat.

Function
REQ-014 SHALL transfer a beat on a port in any cycle where valid and ready are both 1 at the rising edge.
REQ-015 SHALL define load_enable = !out_valid || out_ready; the output register loads only when load_enable is 1.
REQ-016 SHALL hold out_valid, out_data, out_last, out_channel stable while out_valid=1 and out_ready=0.
REQ-017 SHALL present an accepted input beat on the outputs the cycle after the transfer (1-cycle latency); sustained throughput 1 beat/cycle with out_ready=1.
REQ-018 SHALL clear out_valid when load_enable=1 and no input beat transfers in that cycle.
REQ-019 SHALL implement states IDLE and LOCKED plus a lock index and a priority pointer (0..SIZE-1).
REQ-020 In IDLE, SHALL grant the first channel with in_valid=1 searching upward from the pointer, wrapping SIZE-1 -> 0.
REQ-021 SHALL assert at most one in_ready bit per cycle, equal to load_enable and only for the granted/locked channel (combinational path out_ready -> in_ready permitted).
REQ-022 On an IDLE transfer from channel g, SHALL set pointer to (g+1) mod SIZE; with in_last=0 SHALL enter LOCKED with lock index g; with in_last=1 SHALL stay IDLE.
REQ-023 In LOCKED, SHALL grant only the locked channel regardless of other in_valid, and SHALL NOT advance the pointer.
REQ-024 In LOCKED, on a transfer with in_last=1 SHALL return to IDLE; arbitration for the next packet occurs in the following cycle.
REQ-025 In LOCKED with locked in_valid=0, SHALL insert bubbles (out_valid falls once drained) and SHALL NOT serve other channels.
REQ-026 SHALL ignore in_data and in_last of non-transferring channels.

Reset
REQ-027 While resetn=0 at a rising edge, SHALL set out_valid=0, out_data=0, out_last=0, out_channel=0, state IDLE, pointer 0, lock index 0.
REQ-028 While resetn=0, SHALL drive in_ready=0 on all channels; reset mid-packet abandons the lock with no partial-beat output.

Structure
REQ-029 SHALL place no typedefs in a shared package; CHANNEL_WIDTH is a local parameter; the state enum is local.
REQ-030 SHALL use one sub-module, packet_arbiter_mux_select: combinational rotating priority select (requests, pointer -> one-hot grant, grant index).

Verification
REQ-031 Channel 2 alone sends 3-beat packet, out_ready=1 -> out_valid on 3 consecutive cycles starting 1 cycle after first transfer, out_channel=2, out_last=1 only on beat 3.
REQ-032 All 4 channels continuously valid, single-beat packets, out_ready=1, from reset -> out_channel sequence 0,1,2,3,0,1 with no bubbles.
REQ-033 Channel 0 sends 4-beat packet while channels 1..3 valid -> 4 contiguous channel-0 beats, then channel 1.
REQ-034 out_valid=1, out_ready held 0 for 5 cycles -> outputs unchanged, in_ready=0000 throughout; on out_ready=1 next beat follows immediately.
REQ-035 Channel 1 locked mid-packet drops in_valid 3 cycles while channel 2 valid -> no channel-2 beat until channel 1 last beat transferred.
REQ-036 resetn=0 one cycle mid-packet of channel 1 -> out_valid=0 next cycle; afterwards channel 3 alone valid is granted immediately and pointer restarts from 0.

Source files
------------

// File: rtl/packet_arbiter_mux_pkg.sv
// Shared helpers for the packet arbiter mux. It holds only functions: the
// state enum and the channel-width parameter stay local to the modules that use them.
package packet_arbiter_mux_pkg;

    // Returns (base + offset) mod size. Both base and offset must be below size,
    // so a single conditional subtract is enough to wrap the result.
    function automatic int unsigned wrap_index(
        input int unsigned base,
        input int unsigned offset,
        input int unsigned size
    );
        int unsigned sum;
        sum = base + offset;
        return (sum >= size) ? (sum - size) : sum;
    endfunction

endpackage

// File: rtl/packet_arbiter_mux_if.sv
// Stream bundle for the packet arbiter mux: SIZE input channels merged into
// one output stream. The master drives the input channels and consumes the output.
interface packet_arbiter_mux_if #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
);
    localparam int CHANNEL_WIDTH = $clog2(SIZE);

    logic [SIZE-1:0]          in_valid;
    logic [SIZE-1:0]          in_ready;
    logic [SIZE*WIDTH-1:0]    in_data;
    logic [SIZE-1:0]          in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [CHANNEL_WIDTH-1:0] out_channel;

    // Packet sources and the downstream sink
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_channel
    );

    // The arbiter itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_channel
    );

endinterface

// File: rtl/packet_arbiter_mux_select.sv
// Rotating-priority selector: picks the first requesting channel at or above
// the pointer, wrapping from SIZE-1 back to 0. Purely combinational.
module packet_arbiter_mux_select
    import packet_arbiter_mux_pkg::*;
#(
    parameter  int SIZE          = 4,
    localparam int CHANNEL_WIDTH = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]          requests,
    input  logic [CHANNEL_WIDTH-1:0] pointer,
    output logic [SIZE-1:0]          grant,
    output logic [CHANNEL_WIDTH-1:0] grant_index,
    output logic                     grant_valid
);

    logic [CHANNEL_WIDTH-1:0] scan_index;

    // Scan SIZE positions starting at the pointer; the first request found wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        scan_index  = '0;
        for (int k = 0; k < SIZE; k++) begin
            scan_index = CHANNEL_WIDTH'(wrap_index(32'(pointer), k, SIZE));
            if (!grant_valid && requests[scan_index]) begin
                grant[scan_index] = 1'b1;
                grant_index       = scan_index;
                grant_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_arbiter_mux.sv
// Packet-level round-robin multiplexer. Once a channel wins arbitration it keeps
// the output until its last beat passes, so packets are never interleaved. The
// output stage is a single register slice that has one cycle of latency and runs
// at full throughput.
module packet_arbiter_mux
    import packet_arbiter_mux_pkg::*;
#(
    parameter  int SIZE          = 4,
    parameter  int WIDTH         = 8,
    localparam int CHANNEL_WIDTH = $clog2(SIZE)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [SIZE-1:0]          in_valid,
    output logic [SIZE-1:0]          in_ready,
    input  logic [SIZE*WIDTH-1:0]    in_data,
    input  logic [SIZE-1:0]          in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                   state_reg;
    logic [CHANNEL_WIDTH-1:0] lock_reg;
    logic [CHANNEL_WIDTH-1:0] pointer_reg;
    logic                     out_valid_reg;
    logic [WIDTH-1:0]         out_data_reg;
    logic                     out_last_reg;
    logic [CHANNEL_WIDTH-1:0] out_channel_reg;

    logic [SIZE-1:0]          grant;
    logic [CHANNEL_WIDTH-1:0] grant_index;
    logic                     grant_valid;
    logic                     load_enable;
    logic [CHANNEL_WIDTH-1:0] active_channel;
    logic                     active_valid;
    logic                     transfer;
    logic [WIDTH-1:0]         active_data;
    logic                     active_last;
    logic [WIDTH-1:0]         channel_data [SIZE];

    packet_arbiter_mux_select #(
        .SIZE (SIZE)
    ) u_select (
        .requests    (in_valid),
        .pointer     (pointer_reg),
        .grant       (grant),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    // The output register may load when it is empty or being drained this cycle.
    assign load_enable = !out_valid_reg || out_ready;

    // While locked only the lock owner is considered; otherwise the arbiter's pick.
    assign active_channel = (state_reg == LOCKED) ? lock_reg : grant_index;
    assign active_valid   = (state_reg == LOCKED) ? in_valid[lock_reg] : grant_valid;
    assign transfer       = resetn && load_enable && active_valid;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_channel
            // Split the flat data bus into one word per channel for the output mux.
            assign channel_data[gi] = in_data[gi*WIDTH +: WIDTH];

            // Ready goes only to the owning channel and follows load_enable, so a
            // stalled output blocks every input.
            assign in_ready[gi] = resetn && load_enable &&
                                  ((state_reg == LOCKED) ? (lock_reg == CHANNEL_WIDTH'(gi))
                                                         : grant[gi]);
        end
    endgenerate

    assign active_data = channel_data[active_channel];
    assign active_last = in_last[active_channel];

    // Arbitration FSM plus the registered output slice, all updated together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            lock_reg        <= '0;
            pointer_reg     <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_last_reg    <= 1'b0;
            out_channel_reg <= '0;
        end else begin
            if (load_enable) begin
                out_valid_reg <= transfer;
                if (transfer) begin
                    out_data_reg    <= active_data;
                    out_last_reg    <= active_last;
                    out_channel_reg <= active_channel;
                end
            end

            if (transfer) begin
                case (state_reg)
                    IDLE: begin
                        pointer_reg <= CHANNEL_WIDTH'(wrap_index(32'(grant_index), 1, SIZE));
                        if (!active_last) begin
                            state_reg <= LOCKED;
                            lock_reg  <= grant_index;
                        end
                    end
                    LOCKED: begin
                        if (active_last) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_last    = out_last_reg;
    assign out_channel = out_channel_reg;

endmodule

// File: tb/tb_packet_arbiter_mux.sv
// Scenario bench for packet_arbiter_mux: per-channel source queues feed the
// inputs, and the expected output beats are queued when each scenario is set up.
module tb_packet_arbiter_mux;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int CW    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        int               gap;
    } src_beat_t;

    typedef struct {
        logic [CW-1:0]    channel;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_beat_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    packet_arbiter_mux_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    src_beat_t src_q [SIZE][$];
    exp_beat_t exp_q [$];
    bit        xfer  [SIZE];
    int        vectors     = 0;
    int        miscompares = 0;

    packet_arbiter_mux #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (bus.in_valid),
        .in_ready    (bus.in_ready),
        .in_data     (bus.in_data),
        .in_last     (bus.in_last),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready),
        .out_data    (bus.out_data),
        .out_last    (bus.out_last),
        .out_channel (bus.out_channel)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Source driver: pops a beat after its handshake and presents the next one.
    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clock);
            for (int c = 0; c < SIZE; c++) xfer[c] = bus.in_valid[c] && bus.in_ready[c];
            @(posedge clock);
            #1;
            for (int c = 0; c < SIZE; c++) begin
                src_beat_t head;
                if (xfer[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                if (src_q[c].size() == 0) begin
                    bus.in_valid[c]              = 1'b0;
                    bus.in_data[c*WIDTH +: WIDTH] = 8'($urandom);
                    bus.in_last[c]               = 1'($urandom);
                end else if (src_q[c][0].gap > 0) begin
                    head = src_q[c][0];
                    head.gap--;
                    src_q[c][0] = head;
                    bus.in_valid[c]              = 1'b0;
                    bus.in_data[c*WIDTH +: WIDTH] = 8'($urandom);
                    bus.in_last[c]               = 1'($urandom);
                end else begin
                    bus.in_valid[c]              = 1'b1;
                    bus.in_data[c*WIDTH +: WIDTH] = src_q[c][0].data;
                    bus.in_last[c]               = src_q[c][0].last;
                end
            end
        end
    end

    // Output monitor: every accepted output beat is checked against the scoreboard.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clock);
            if (resetn && bus.out_valid && bus.out_ready) begin
                $display("beat ch=%0d data=%02h last=%0b", bus.out_channel, bus.out_data, bus.out_last);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_unexpected: got ch=%0d data=%02h last=%0b, required no beat",
                             bus.out_channel, bus.out_data, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_channel !== e.channel || bus.out_data !== e.data || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL scoreboard_beat: got ch=%0d data=%02h last=%0b, required ch=%0d data=%02h last=%0b",
                                 bus.out_channel, bus.out_data, bus.out_last, e.channel, e.data, e.last);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic push_src(input int ch, input logic [WIDTH-1:0] data, input logic last, input int gap);
        src_beat_t b;
        b.data = data;
        b.last = last;
        b.gap  = gap;
        src_q[ch].push_back(b);
    endtask

    task automatic push_exp(input int ch, input logic [WIDTH-1:0] data, input logic last);
        exp_beat_t e;
        e.channel = CW'(ch);
        e.data    = data;
        e.last    = last;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        step();
        resetn        = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < SIZE; c++) src_q[c].delete();
        exp_q.delete();
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            at_neg();
            n++;
        end
        step();
    endtask

    task automatic wait_out_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            at_neg();
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        for (int c = 0; c < SIZE; c++) push_src(c, 8'(8'hA0 + c), 1'b0, 0);
        step();
        for (int n = 0; n < 3; n++) begin
            at_neg();
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_in_ready: got %b, required 0000", bus.in_ready);
            end
            vectors++;
            if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_channel} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_outputs: got valid=%b data=%02h last=%b ch=%0d, required all 0",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_channel);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_packet();
        bit found;
        apply_reset();
        push_src(2, 8'h20, 1'b0, 0); push_exp(2, 8'h20, 1'b0);
        push_src(2, 8'h21, 1'b0, 0); push_exp(2, 8'h21, 1'b0);
        push_src(2, 8'h22, 1'b1, 0); push_exp(2, 8'h22, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            if (bus.in_valid[2] && bus.in_ready[2]) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL single_first_transfer: got no transfer on ch2, required one within 20 cycles");
        end
        for (int b = 0; b < 3; b++) begin
            at_neg();
            vectors++;
            if ({bus.out_valid, bus.out_channel, bus.out_last} !== {1'b1, 2'd2, 1'(b == 2)}) begin
                miscompares++;
                $display("FAIL single_beat%0d: got valid=%b ch=%0d last=%b, required valid=1 ch=2 last=%0b",
                         b, bus.out_valid, bus.out_channel, bus.out_last, b == 2);
            end
        end
        at_neg();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: got out_valid=%b, required 0", bus.out_valid);
        end
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 0; c < SIZE; c++) begin
                push_src(c, 8'(16 * c + rep), 1'b1, 0);
                push_exp(c, 8'(16 * c + rep), 1'b1);
            end
        end
        wait_out_valid(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_start: got no output, required output within 20 cycles");
        end
        for (int n = 1; n < 8; n++) begin
            at_neg();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_channel !== CW'(n % SIZE)) begin
                miscompares++;
                $display("FAIL rr_slot%0d: got valid=%b ch=%0d, required valid=1 ch=%0d",
                         n, bus.out_valid, bus.out_channel, n % SIZE);
            end
        end
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rr_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_locked_packet();
        bit ok;
        int exp_ch [7];
        exp_ch = '{0, 0, 0, 0, 1, 2, 3};
        apply_reset();
        for (int b = 0; b < 4; b++) begin
            push_src(0, 8'(8'h40 + b), 1'(b == 3), 0);
            push_exp(0, 8'(8'h40 + b), 1'(b == 3));
        end
        for (int c = 1; c < SIZE; c++) begin
            push_src(c, 8'(8'h50 + c), 1'b1, 0);
            push_exp(c, 8'(8'h50 + c), 1'b1);
        end
        wait_out_valid(20, ok);
        vectors++;
        if (!ok || bus.out_channel !== 2'd0) begin
            miscompares++;
            $display("FAIL lock_start: got valid=%b ch=%0d, required valid=1 ch=0", ok, bus.out_channel);
        end
        for (int n = 1; n < 7; n++) begin
            at_neg();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_channel !== CW'(exp_ch[n])) begin
                miscompares++;
                $display("FAIL lock_slot%0d: got valid=%b ch=%0d, required valid=1 ch=%0d",
                         n, bus.out_valid, bus.out_channel, exp_ch[n]);
            end
        end
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL lock_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        bus.out_ready = 1'b0;
        push_src(0, 8'h05, 1'b1, 0); push_exp(0, 8'h05, 1'b1);
        push_src(1, 8'h15, 1'b1, 0); push_exp(1, 8'h15, 1'b1);
        wait_out_valid(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_start: got no output, required output within 20 cycles");
        end
        for (int n = 0; n < 5; n++) begin
            at_neg();
            vectors++;
            if ({bus.out_valid, bus.out_channel, bus.out_data, bus.out_last} !== {1'b1, 2'd0, 8'h05, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got valid=%b ch=%0d data=%02h last=%b, required valid=1 ch=0 data=05 last=1",
                         n, bus.out_valid, bus.out_channel, bus.out_data, bus.out_last);
            end
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_in_ready%0d: got %b, required 0000", n, bus.in_ready);
            end
        end
        step();
        bus.out_ready = 1'b1;
        at_neg();
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b, required 0010", bus.in_ready);
        end
        at_neg();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_channel !== 2'd1) begin
            miscompares++;
            $display("FAIL stall_next_beat: got valid=%b ch=%0d, required valid=1 ch=1", bus.out_valid, bus.out_channel);
        end
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_lock_hold();
        bit ch1_done;
        bit started;
        bit bubble_seen;
        apply_reset();
        push_src(1, 8'h10, 1'b0, 0); push_exp(1, 8'h10, 1'b0);
        push_src(1, 8'h11, 1'b0, 3); push_exp(1, 8'h11, 1'b0);
        push_src(1, 8'h12, 1'b1, 0); push_exp(1, 8'h12, 1'b1);
        push_src(2, 8'h20, 1'b1, 0); push_exp(2, 8'h20, 1'b1);
        ch1_done    = 1'b0;
        started     = 1'b0;
        bubble_seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            at_neg();
            if (bus.out_valid === 1'b1) started = 1'b1;
            else if (started && !ch1_done) bubble_seen = 1'b1;
            if (!ch1_done) begin
                vectors++;
                if (bus.in_ready[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_ch2_ready: got 1 at cycle %0d, required 0 while ch1 locked", n);
                end
            end
            if (bus.in_valid[1] && bus.in_ready[1] && bus.in_last[1]) ch1_done = 1'b1;
        end
        vectors++;
        if (bubble_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_bubble: got no bubble, required out_valid to fall during ch1 gap");
        end
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        bit found;
        apply_reset();
        push_src(1, 8'h30, 1'b0, 0);
        push_src(1, 8'h31, 1'b0, 0);
        push_src(1, 8'h32, 1'b1, 0);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            if (bus.in_valid[1] && bus.in_ready[1]) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midrst_first_transfer: got no transfer on ch1, required one within 20 cycles");
        end
        step();
        resetn = 1'b0;
        src_q[1].delete();
        exp_q.delete();
        at_neg();
        vectors++;
        if (bus.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_in_ready: got %b, required 0000", bus.in_ready);
        end
        at_neg();
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_channel} !== 12'h000) begin
            miscompares++;
            $display("FAIL midrst_outputs: got valid=%b data=%02h last=%b ch=%0d, required all 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_channel);
        end
        step();
        resetn = 1'b1;
        push_src(3, 8'h3A, 1'b1, 0); push_exp(3, 8'h3A, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            at_neg();
            if (bus.in_valid[3]) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found || bus.in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL midrst_ch3_grant: got in_ready=%b, required 1000", bus.in_ready);
        end
        at_neg();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_channel !== 2'd3) begin
            miscompares++;
            $display("FAIL midrst_ch3_out: got valid=%b ch=%0d, required valid=1 ch=3", bus.out_valid, bus.out_channel);
        end
        step();
        push_src(2, 8'h2B, 1'b1, 0);
        push_src(0, 8'h0B, 1'b1, 0);
        push_exp(0, 8'h0B, 1'b1);
        push_exp(2, 8'h2B, 1'b1);
        wait_drain(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_locked_packet();
        test_backpressure();
        test_lock_hold();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
